level_meter: RTL
================

LEVEL_METER -- requirements
Module: level_meter

Interface
REQ-001 SHALL have parameter WINDOW_LOG2, default 9, log2 of the number of valid samples per level window (512 samples at 44100 Hz gives about 86 Hz updates).
REQ-002 SHALL have port dclk  input  1  sample clock, 44100 Hz; all logic on posedge dclk.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port sample_valid  input  1  qualifies sample for one dclk cycle.
REQ-005 SHALL have port sample  input  12  unsigned ADC code, mid-scale 2048, synchronous to dclk.
REQ-006 SHALL have port level  output  6  registered magnitude for the LED bar stage, held between updates.
REQ-007 SHALL have port level_valid  output  1  one-cycle pulse coincident with each level update.

Function
REQ-008 SHALL compute the 11-bit magnitude as sample-2048 when sample>=2048, else 2047-sample (range 0..2047, no overflow).
REQ-009 SHALL register the magnitude in pipeline stage 1 on any cycle with sample_valid high.
REQ-010 SHALL, in stage 2, update peak to max(peak, stage-1 magnitude) and advance a WINDOW_LOG2-bit sample counter, one step per valid sample.
REQ-011 SHALL ignore cycles with sample_valid low: counter, peak, level and stage-1 data are unchanged.
REQ-012 SHALL close a window when the counter wraps from 2^WINDOW_LOG2-1 to 0; the wrapping sample is included in the closing window.
REQ-013 SHALL, on window close, load level from the closed window's peak bits [10:5] and pulse level_valid high for exactly one dclk cycle.
REQ-014 SHALL have latency of exactly 2 dclk cycles from the dclk edge capturing the last valid sample of a window to level/level_valid being visible.
REQ-015 SHALL start each new window's peak at that window's first magnitude, so no value from the prior window carries over.
REQ-016 SHALL handle back-to-back valid samples every cycle, including the window-closing sample immediately followed by a new-window sample, without loss.
REQ-017 SHALL implement a two-state control FSM: ACCUM (collecting) -> PUBLISH on counter wrap; PUBLISH -> ACCUM unconditionally after one cycle; accumulation continues during PUBLISH.

Reset
REQ-018 SHALL, on rst high, asynchronously clear level to 0, level_valid to 0, peak to 0, counter to 0, stage-1 valid to 0, and set the FSM to ACCUM.
REQ-019 SHALL, on rst mid-window, discard the partial window with no level_valid pulse; the first window after reset release is a full 2^WINDOW_LOG2 valid samples.

Configuration
REQ-020 SHALL, when macro LEVEL_METER_DECAY_EN is defined, hold level against falling input: on window close, level becomes the window peak[10:5] if that is >= the current level, else level-1, saturating at 0.
REQ-021 SHALL, when LEVEL_METER_DECAY_EN is undefined, load level directly from the window peak[10:5] on every window close, with no decay logic synthesized.

Structure
REQ-022 SHALL place MID_SCALE (2048), SAMPLE_W (12), MAG_W (11), LEVEL_W (6) and the FSM state typedef in shared package level_meter_pkg.
REQ-023 SHALL implement the REQ-008 magnitude function as one combinational sub-module, abs_center, instanced once.

Verification
REQ-024 SHALL cover the constant mid-scale case: 512 valid samples of 2048 -> one level_valid pulse, level=0.
REQ-025 SHALL cover full-scale extremes: a window containing 0 and 4095 (others 2048) -> level=63; a window of 3072 only -> magnitude 1024, level=32.
REQ-026 SHALL cover gapped valid input: 512 valid samples of 2560 interleaved with random sample_valid-low cycles -> exactly one pulse, level=16, 2 cycles after the 512th valid edge.
REQ-027 SHALL cover reset mid-window: rst asserted after 300 valid samples of 4095 -> level=0 immediately; no pulse until 512 further valid samples; window level then matches post-reset data only.
REQ-028 SHALL cover decay, with the macro defined: window of 4095 (level 63) then three windows of 2048 -> levels 62, 61, 60; with the macro undefined -> 0, 0, 0.
REQ-029 SHALL cover continuous streaming: valid every cycle for 4 windows at 2048+64*k (k=1..4) -> pulses every 512 cycles, levels 2, 4, 6, 8.

Source files
------------

// File: rtl/level_meter_pkg.sv
// Shared widths, mid-scale constant and control-state encoding for the level meter.
package level_meter_pkg;
  localparam int MID_SCALE = 2048;
  localparam int SAMPLE_W  = 12;
  localparam int MAG_W     = 11;
  localparam int LEVEL_W   = 6;

  typedef enum logic {
    ACCUM   = 1'b0,
    PUBLISH = 1'b1
  } state_e;
endpackage

// File: rtl/level_meter_abs_center.sv
// Purely combinational distance of an unsigned ADC code from mid-scale (0..2047).
module abs_center
  import level_meter_pkg::*;
(
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic [MAG_W-1:0]    mag_o
);
  // Above mid-scale: code-2048 is the low bits; below: 2047-code is their inverse.
  always_comb begin
    if (sample_i[SAMPLE_W-1]) mag_o = sample_i[MAG_W-1:0];
    else                      mag_o = ~sample_i[MAG_W-1:0];
  end
endmodule

// File: rtl/level_meter.sv
// Windowed peak meter: 2-stage pipeline, publishes peak[10:5] every 2^WINDOW_LOG2 valid samples.
// Define LEVEL_METER_DECAY_EN to let the displayed level fall by at most one step per window.
module level_meter
  import level_meter_pkg::*;
#(
  parameter int WINDOW_LOG2 = 9
) (
  input  logic                dclk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [LEVEL_W-1:0]  level,
  output logic                level_valid
);
  logic [MAG_W-1:0]       mag;
  logic [MAG_W-1:0]       s1_mag_q, s1_mag_d;
  logic                   s1_vld_q, s1_vld_d;
  logic [MAG_W-1:0]       peak_q, peak_d;
  logic [MAG_W-1:0]       win_peak_q, win_peak_d;
  logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
  logic [LEVEL_W-1:0]     level_q, level_d;
  logic                   level_vld_q, level_vld_d;
  state_e                 state_q, state_d;

  logic                   wrap;
  logic [MAG_W-1:0]       peak_max;
  logic [LEVEL_W-1:0]     win_lvl;

  abs_center u_abs_center (
    .sample_i (sample),
    .mag_o    (mag)
  );

  assign wrap     = s1_vld_q && (cnt_q == '1);
  assign peak_max = (s1_mag_q > peak_q) ? s1_mag_q : peak_q;
  assign win_lvl  = win_peak_q[MAG_W-1:MAG_W-LEVEL_W];

  always_comb begin
    s1_mag_d    = s1_mag_q;
    s1_vld_d    = sample_valid;
    peak_d      = peak_q;
    win_peak_d  = win_peak_q;
    cnt_d       = cnt_q;
    level_d     = level_q;
    level_vld_d = 1'b0;
    state_d     = state_q;

    if (sample_valid) s1_mag_d = mag;

    // Closing sample is folded into the latched window peak; clearing to 0
    // lets the next window's first magnitude become its starting peak.
    if (s1_vld_q) begin
      cnt_d = cnt_q + WINDOW_LOG2'(1);
      if (wrap) begin
        win_peak_d = peak_max;
        peak_d     = '0;
      end else begin
        peak_d     = peak_max;
      end
    end

    case (state_q)
      ACCUM: begin
        if (wrap) state_d = PUBLISH;
      end
      PUBLISH: begin
        state_d     = ACCUM;
        level_vld_d = 1'b1;
`ifdef LEVEL_METER_DECAY_EN
        if (win_lvl >= level_q)   level_d = win_lvl;
        else if (level_q != '0)   level_d = level_q - LEVEL_W'(1);
        else                      level_d = '0;
`else
        level_d = win_lvl;
`endif
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      s1_mag_q    <= '0;
      s1_vld_q    <= 1'b0;
      peak_q      <= '0;
      win_peak_q  <= '0;
      cnt_q       <= '0;
      level_q     <= '0;
      level_vld_q <= 1'b0;
      state_q     <= ACCUM;
    end else begin
      s1_mag_q    <= s1_mag_d;
      s1_vld_q    <= s1_vld_d;
      peak_q      <= peak_d;
      win_peak_q  <= win_peak_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_vld_q <= level_vld_d;
      state_q     <= state_d;
    end
  end

  assign level       = level_q;
  assign level_valid = level_vld_q;
endmodule
